// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter
//
// Round-robin controller that shares one bank of WIDTH SR flip-flops among
// NREQ requesters. One command (clear, set, toggle or nop on a masked subset
// of bits) is sequenced at a time onto the bank's s/r lines, and s and r are
// never high together on any bit.
//
// Each command takes three cycles: IDLE (arbitrate), DRIVE (gnt/s/r valid,
// bank captures on the edge ending DRIVE), ACK (done pulse, s=r=0).
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - asynchronous active-high reset
//   req   - per-requester pending command
//   op    - op[2i+1:2i] for requester i: 00 nop, 01 clear, 10 set, 11 toggle
//   mask  - mask[WIDTH*i +: WIDTH] selects the bits requester i affects
//   q     - current bank outputs, read back to resolve toggles
//   gnt   - registered one-hot grant, held through DRIVE and ACK
//   s     - registered set lines to the bank
//   r     - registered reset lines to the bank
//   done  - one-cycle completion pulse during ACK
//   busy  - high whenever the controller is not idle
module sr_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   mask,
  input  logic [WIDTH-1:0]        q,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        s,
  output logic [WIDTH-1:0]        r,
  output logic                    done,
  output logic                    busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] OpClear  = 2'b01;
  localparam logic [1:0] OpSet    = 2'b10;
  localparam logic [1:0] OpToggle = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StAck
  } state_e;

  state_e            state_q;
  logic [PtrW-1:0]   ptr_q;
  logic [PtrW-1:0]   win_q;
  logic [NREQ-1:0]   gnt_q;
  logic [WIDTH-1:0]  s_q;
  logic [WIDTH-1:0]  r_q;
  logic              done_q;

  logic              win_found;
  logic [PtrW-1:0]   win_idx;
  logic [1:0]        op_w;
  logic [WIDTH-1:0]  mask_w;
  logic [WIDTH-1:0]  set_d;
  logic [WIDTH-1:0]  clr_d;
  logic [NREQ-1:0]   gnt_d;
  logic [PtrW-1:0]   ptr_next;

  // Round-robin search: first pass covers ptr..NREQ-1, second pass wraps to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_found && (i >= 32'(ptr_q)) && req[i]) begin
        win_found = 1'b1;
        win_idx   = PtrW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_idx   = PtrW'(i);
      end
    end
  end

  // Select the winner's op and mask.
  always_comb begin
    op_w   = 2'b00;
    mask_w = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == PtrW'(i)) begin
        op_w   = op[2*i +: 2];
        mask_w = mask[WIDTH*i +: WIDTH];
      end
    end
  end

  // Translate the command into disjoint set/clear vectors. Toggle splits the
  // mask by the current bank value so each bit gets exactly one of s or r.
  always_comb begin
    set_d = '0;
    clr_d = '0;
    case (op_w)
      OpClear:  clr_d = mask_w;
      OpSet:    set_d = mask_w;
      OpToggle: begin
        set_d = mask_w & ~q;
        clr_d = mask_w & q;
      end
      default: ;
    endcase
  end

  assign gnt_d    = NREQ'(1) << win_idx;
  assign ptr_next = (win_q == PtrW'(NREQ - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q <= StDrive;
            win_q   <= win_idx;
            gnt_q   <= gnt_d;
            s_q     <= set_d;
            r_q     <= clr_d;
          end
        end
        StDrive: begin
          state_q <= StAck;
          s_q     <= '0;
          r_q     <= '0;
          done_q  <= 1'b1;
          ptr_q   <= ptr_next;
        end
        StAck: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          gnt_q   <= '0;
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          s_q     <= '0;
          r_q     <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign s    = s_q;
  assign r    = r_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Self-checking bench for sr_bank_arbiter with a behavioural SR bank model.
module tb_sr_bank_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] mask;
  logic [WIDTH-1:0]      bank_q;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      s;
  logic [WIDTH-1:0]      r;
  logic                  done;
  logic                  busy;

  logic                  load;
  logic [WIDTH-1:0]      load_val;

  int n_checks = 0;
  int n_fail   = 0;

  sr_bank_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .op    (op),
    .mask  (mask),
    .q     (bank_q),
    .gnt   (gnt),
    .s     (s),
    .r     (r),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SR bank: set and reset lines act on the rising edge; bench can preload it.
  always @(posedge clk) begin
    if (load) bank_q <= load_val;
    else      bank_q <= (bank_q & ~r) | s;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // s and r must never overlap on any bit.
  always @(negedge clk) begin
    check("s_r_disjoint", 32'(s & r), 32'h0);
  end

  task automatic issue(input int i, input logic [1:0] o, input logic [7:0] m);
    req[i]          = 1'b1;
    op[2*i +: 2]    = o;
    mask[8*i +: 8]  = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] apply_op(input logic [7:0] cur, input logic [1:0] o,
                                          input logic [7:0] m);
    case (o)
      2'b01:   return cur & ~m;
      2'b10:   return cur | m;
      2'b11:   return cur ^ m;
      default: return cur;
    endcase
  endfunction

  int          exp_order [6] = '{0, 1, 2, 3, 0, 1};
  logic [7:0]  exp_q;

  initial begin
    reset    = 1'b1;
    req      = '0;
    op       = '0;
    mask     = '0;
    load     = 1'b1;
    load_val = 8'h00;
    bank_q   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    load  = 1'b0;
    reset = 1'b0;

    // Reset state.
    check("rst_gnt",  32'(gnt),  32'h0);
    check("rst_s",    32'(s),    32'h0);
    check("rst_r",    32'(r),    32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Set on requester 0.
    issue(0, 2'b10, 8'h0F);
    @(negedge clk);
    check("set_gnt",  32'(gnt),  32'h1);
    check("set_s",    32'(s),    32'h0F);
    check("set_r",    32'(r),    32'h00);
    check("set_busy", 32'(busy), 32'h1);
    check("set_drv_done", 32'(done), 32'h0);
    req = '0;
    @(negedge clk);
    check("set_done", 32'(done),   32'h1);
    check("set_q",    32'(bank_q), 32'h0F);
    check("set_ack_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    check("set_idle_busy", 32'(busy), 32'h0);
    check("set_idle_done", 32'(done), 32'h0);
    check("set_idle_gnt",  32'(gnt),  32'h0);

    // Toggle on requester 1 with bank preloaded to 0x3C, then toggle back.
    load = 1'b1; load_val = 8'h3C;
    @(negedge clk);
    load = 1'b0;
    check("tgl_pre_q", 32'(bank_q), 32'h3C);
    for (int k = 0; k < 2; k++) begin
      issue(1, 2'b11, 8'hFF);
      @(negedge clk);
      check("tgl_gnt", 32'(gnt), 32'h2);
      check("tgl_s",   32'(s),   (k == 0) ? 32'hC3 : 32'h3C);
      check("tgl_r",   32'(r),   (k == 0) ? 32'h3C : 32'hC3);
      req = '0;
      @(negedge clk);
      check("tgl_done", 32'(done),   32'h1);
      check("tgl_q",    32'(bank_q), (k == 0) ? 32'hC3 : 32'h3C);
      @(negedge clk);
    end

    // Nop with full mask on requester 2.
    issue(2, 2'b00, 8'hFF);
    @(negedge clk);
    check("nop_gnt", 32'(gnt), 32'h4);
    check("nop_s",   32'(s),   32'h0);
    check("nop_r",   32'(r),   32'h0);
    req = '0;
    @(negedge clk);
    check("nop_done", 32'(done),   32'h1);
    check("nop_q",    32'(bank_q), 32'h3C);
    @(negedge clk);

    // Strict rotation with all requesters re-requesting.
    do_reset();
    for (int i = 0; i < 4; i++) issue(i, 2'b00, 8'h00);
    begin
      int ng    = 0;
      int last  = 0;
      int cyc   = 0;
      int raise = -1;
      while (ng < 6 && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (raise >= 0) begin
          req[raise] = 1'b1;
          raise = -1;
        end
        if (gnt != '0 && !done) begin
          check("rot_gnt", 32'(gnt), 32'(1) << exp_order[ng]);
          if (ng > 0) check("rot_spacing", 32'(cyc - last), 32'd3);
          last = cyc;
          ng++;
        end else if (done) begin
          for (int i = 0; i < 4; i++) begin
            if (gnt[i]) begin
              req[i] = 1'b0;
              raise  = i;
            end
          end
        end
      end
      check("rot_count", 32'(ng), 32'd6);
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Random single-requester commands against a reference bank model.
    load = 1'b1; load_val = 8'h00;
    @(negedge clk);
    load  = 1'b0;
    exp_q = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      int         i;
      logic [1:0] o;
      logic [7:0] m;
      i = int'($urandom_range(0, 3));
      o = 2'($urandom_range(0, 3));
      m = 8'($urandom_range(0, 255));
      issue(i, o, m);
      @(negedge clk);
      check("rnd_gnt", 32'(gnt), 32'(1) << i);
      req   = '0;
      exp_q = apply_op(exp_q, o, m);
      @(negedge clk);
      check("rnd_done", 32'(done),   32'h1);
      check("rnd_q",    32'(bank_q), 32'(exp_q));
      @(negedge clk);
    end

    // Reset in the middle of DRIVE.
    issue(3, 2'b10, 8'hFF);
    @(negedge clk);
    check("mid_drv_s",   32'(s),   32'hFF);
    check("mid_drv_gnt", 32'(gnt), 32'h8);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_s",    32'(s),    32'h0);
    check("mid_rst_r",    32'(r),    32'h0);
    check("mid_rst_gnt",  32'(gnt),  32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    issue(0, 2'b10, 8'h01);
    @(negedge clk);
    check("mid_rst_nodone", 32'(done),   32'h0);
    check("mid_rst_q",      32'(bank_q), 32'(exp_q));
    reset = 1'b0;
    @(negedge clk);
    check("tie_gnt", 32'(gnt), 32'h1);
    check("tie_s",   32'(s),   32'h01);
    req = '0;
    @(negedge clk);
    check("tie_done", 32'(done),   32'h1);
    check("tie_q",    32'(bank_q), 32'(exp_q | 8'h01));
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_bank_arbiter.md
# sr_bank_arbiter

Round-robin controller that shares one bank of WIDTH SR flip-flops among NREQ requesters. Each requester asks for a set, clear or toggle of a masked subset of bits. The arbiter sequences one command at a time onto the bank's s/r lines and never drives s=r=1 on any bit. It sits between the control logic and the SR register bank, whose q outputs it reads back to resolve toggles.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: number of SR flip-flops in the shared bank.
- clk  in  1: single clock; all state updates on its rising edge.
- reset  in  1: asynchronous, active-high; clears all state immediately.
- req  in  NREQ: req[i] high = requester i has a pending command.
- op  in  2*NREQ: op[2i+1:2i] for requester i; 00 nop, 01 clear, 10 set, 11 toggle.
- mask  in  WIDTH*NREQ: mask[WIDTH*i +: WIDTH] selects the bits requester i affects.
- q  in  WIDTH: current bank outputs, used for toggle.
- gnt  out  NREQ: one-hot grant, registered.
- s  out  WIDTH: set lines to the bank, registered.
- r  out  WIDTH: reset lines to the bank, registered.
- done  out  1: one-cycle completion pulse for the granted requester.
- busy  out  1: high whenever state is not IDLE.

## Operation
- States: IDLE, DRIVE, ACK.
- IDLE:
  - s=r=0, gnt=0, done=0.
  - If any req bit is high at a clock edge, choose the winner and go to DRIVE.
  - Winner is the first requester with req high, searching from ptr upward and wrapping.
- On the DRIVE entry edge, the following are latched from the winner's op, mask and q at that edge:
  - clear: s=0, r=mask.
  - set: s=mask, r=0.
  - toggle: s=mask&~q, r=mask&q.
  - nop: s=r=0; the full handshake still occurs.
- DRIVE: gnt, s and r are held for exactly one cycle. The bank captures them on the edge that ends DRIVE. Next state is ACK.
- ACK:
  - s=r=0, so the bank holds.
  - done=1 and gnt is unchanged.
  - ptr is set to (winner+1) mod NREQ.
  - Next state is IDLE.
- Requester handshake: the requester must drop req by the edge that ends ACK. A req still high in IDLE is treated as a new request.
- req, op and mask are sampled only at the IDLE→DRIVE edge. Changes during DRIVE or ACK are ignored.
- Invariant: (s & r) == 0 in every cycle, for every op, mask and q.
- mask = 0 behaves as nop.

## Timing
- Reset values: state=IDLE, ptr=0, gnt=0, s=0, r=0, done=0, busy=0.
- Reset asserted mid-DRIVE: s and r drop to 0 immediately (asynchronously). No done pulse is produced and the command is lost.
- Per-command timeline, with req seen at edge E0 in IDLE:
  - E0→E1: DRIVE (gnt, s, r valid).
  - Bank updates at E1.
  - E1→E2: ACK (done=1, q already updated).
  - E2→: IDLE.
- Latency from sampled req to done is 2 cycles. Minimum spacing between grants is 3 cycles.
- Simultaneous requests: exactly one grant per arbitration. With all NREQ requesters continuously re-requesting, each is granted once per NREQ grants (strict rotation).
- ptr wrap-around: after requester NREQ-1 is served, the search starts at 0.
- Toggle uses q as sampled at the DRIVE entry edge. A bit toggled twice by successive commands therefore returns to its original value.

## Test plan
- Reset, then req=0001, op0=10, mask0=0x0F:
  - DRIVE cycle shows gnt=0001, s=0x0F, r=0x00.
  - Next cycle done=1 and bank q=0x0F.
  - Next cycle IDLE, busy=0.
- Bank q=0x3C, req=0010, op1=11, mask1=0xFF:
  - DRIVE shows s=0xC3, r=0x3C.
  - After completion q=0xC3.
  - Repeating the command returns q=0x3C.
- req=1111 held, each requester dropping req after its done and re-raising it 1 cycle later:
  - Grant order 0,1,2,3,0,1.
  - Each grant is 3 cycles apart; gnt is always one-hot.
- Random op/mask/q for 10,000 commands: s&r==0 every cycle; bank result equals the op applied to the masked bits.
- op=00 with mask=0xFF: s=r=0 in DRIVE, done still pulses, q unchanged.
- Reset asserted in the middle of DRIVE: s, r and gnt go to 0 without waiting for a clock edge, no done pulse occurs, and after release ptr=0 so requester 0 wins a tie against 3.
